// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with optional skid entry, hazard stall/flush, and
// control payload zeroed on bubbles. occupancy_o doubles as the FSM state view.
module pipe_stage_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 2,
  parameter int SKID   = 1
) (
  input  logic              clk_i,
  input  logic              start_i,
  input  logic              in_valid_i,
  output logic              in_ready_o,
  input  logic [DATA_W-1:0] in_data_i,
  input  logic [CTRL_W-1:0] in_ctrl_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              out_valid_o,
  input  logic              out_ready_i,
  output logic [DATA_W-1:0] out_data_o,
  output logic [CTRL_W-1:0] out_ctrl_o,
  output logic [1:0]        occupancy_o
);

  // Handshake: an entry moves upstream->stage when in_valid_i & in_ready_o,
  // and stage->downstream when out_valid_o & out_ready_i & ~stall_i; both
  // are judged in the same cycle and neither waits on the other's valid.

  localparam bit HAS_SKID = (SKID != 0);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q;
  logic              out_valid_q;
  logic [DATA_W-1:0] head_data_q;
  logic [CTRL_W-1:0] head_ctrl_q;
  logic [DATA_W-1:0] skid_data_q;
  logic [CTRL_W-1:0] skid_ctrl_q;

  logic accept;
  logic xfer;

  // With a skid entry, ready depends only on registered state; without one,
  // a full stage may still accept when the head leaves this same cycle.
  always_comb begin
    in_ready_o = 1'b0;
    if (HAS_SKID) begin
      in_ready_o = start_i & ~stall_i & (state_q != TWO);
    end else begin
      in_ready_o = start_i & ~stall_i & ((state_q == EMPTY) | out_ready_i);
    end
  end

  assign accept = in_valid_i & in_ready_o;
  assign xfer   = out_valid_q & out_ready_i & ~stall_i;

  always_ff @(posedge clk_i) begin
    if (!start_i) begin
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      head_data_q <= '0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else if (flush_i) begin
      // Flush outranks stall; head data is kept so out_data_o holds its value.
      state_q     <= EMPTY;
      out_valid_q <= 1'b0;
      head_ctrl_q <= '0;
      skid_data_q <= '0;
      skid_ctrl_q <= '0;
    end else begin
      case (state_q)
        EMPTY: begin
          if (accept) begin
            head_data_q <= in_data_i;
            head_ctrl_q <= in_ctrl_i;
            out_valid_q <= 1'b1;
            state_q     <= ONE;
          end
        end
        ONE: begin
          if (accept && xfer) begin
            head_data_q <= in_data_i;
            head_ctrl_q <= in_ctrl_i;
          end else if (accept && HAS_SKID) begin
            skid_data_q <= in_data_i;
            skid_ctrl_q <= in_ctrl_i;
            state_q     <= TWO;
          end else if (xfer) begin
            head_ctrl_q <= '0;
            out_valid_q <= 1'b0;
            state_q     <= EMPTY;
          end
        end
        TWO: begin
          if (xfer) begin
            head_data_q <= skid_data_q;
            head_ctrl_q <= skid_ctrl_q;
            skid_ctrl_q <= '0;
            state_q     <= ONE;
          end
        end
        default: begin
          out_valid_q <= 1'b0;
          head_ctrl_q <= '0;
          state_q     <= EMPTY;
        end
      endcase
    end
  end

  assign out_valid_o = out_valid_q;
  assign out_data_o  = head_data_q;
  // Bubbles must never carry live control bits (e.g. RegWrite).
  assign out_ctrl_o  = out_valid_q ? head_ctrl_q : '0;
  assign occupancy_o = state_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed bench for the SKID=1 stage plus a randomized scoreboard run on a
// SKID=0 instance.
module tb_pipe_stage_reg;

  localparam int DW  = 64;
  localparam int CW  = 2;
  localparam int DW0 = 16;
  localparam int CW0 = 2;
  localparam int QW  = DW0 + CW0;

  // ---------------- clock / reset ----------------
  logic clk;
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SKID=1 instance
  logic          start, in_valid, in_ready, stall, flush, out_valid, out_ready;
  logic [DW-1:0] in_data, out_data;
  logic [CW-1:0] in_ctrl, out_ctrl;
  logic [1:0]    occ;

  // SKID=0 instance
  logic           start0, in_valid0, in_ready0, stall0, flush0, out_valid0, out_ready0;
  logic [DW0-1:0] in_data0, out_data0;
  logic [CW0-1:0] in_ctrl0, out_ctrl0;
  logic [1:0]     occ0;

  pipe_stage_reg #(.DATA_W(DW), .CTRL_W(CW), .SKID(1)) u_dut (
    .clk_i(clk), .start_i(start), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .in_data_i(in_data), .in_ctrl_i(in_ctrl), .stall_i(stall), .flush_i(flush),
    .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
    .out_ctrl_o(out_ctrl), .occupancy_o(occ)
  );

  pipe_stage_reg #(.DATA_W(DW0), .CTRL_W(CW0), .SKID(0)) u_dut0 (
    .clk_i(clk), .start_i(start0), .in_valid_i(in_valid0), .in_ready_o(in_ready0),
    .in_data_i(in_data0), .in_ctrl_i(in_ctrl0), .stall_i(stall0), .flush_i(flush0),
    .out_valid_o(out_valid0), .out_ready_i(out_ready0), .out_data_o(out_data0),
    .out_ctrl_o(out_ctrl0), .occupancy_o(occ0)
  );

  // ---------------- scoreboard state ----------------
  int tests = 0;
  int fails = 0;
  logic [QW-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic [CW-1:0] c,
                       input logic ordy, input logic st, input logic fl);
    in_valid  = v;
    in_data   = d;
    in_ctrl   = c;
    out_ready = ordy;
    stall     = st;
    flush     = fl;
    #1;
  endtask

  task automatic fill_ab(input string tag);
    drive(1'b1, 64'hA, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 64'hB, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    chk({tag, "_fill_occ"}, 64'(occ), 64'd2);
  endtask

  task automatic chk_out(input string tag, input logic v, input logic [DW-1:0] d,
                         input logic [CW-1:0] c, input logic [1:0] o);
    chk({tag, "_valid"}, 64'(out_valid), 64'(v));
    chk({tag, "_data"},  out_data,       d);
    chk({tag, "_ctrl"},  64'(out_ctrl),  64'(c));
    chk({tag, "_occ"},   64'(occ),       64'(o));
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic          exp_rdy, acc, xf;
    logic [QW-1:0] head;

    start = 1'b0; start0 = 1'b0;
    in_valid0 = 1'b0; in_data0 = '0; in_ctrl0 = '0;
    stall0 = 1'b0; flush0 = 1'b0; out_ready0 = 1'b0;
    drive(1'b1, 64'h77, 2'd3, 1'b1, 1'b0, 1'b0);

    // reset
    tick(); tick();
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    chk_out("rst", 1'b0, 64'h0, 2'd0, 2'd0);
    chk("rst0_occ", 64'(occ0), 64'd0);

    // single entry then gapless stream
    start = 1'b1; start0 = 1'b1;
    drive(1'b1, 64'h11, 2'd3, 1'b1, 1'b0, 1'b0);
    chk("s_in_ready", 64'(in_ready), 64'd1);
    tick();
    chk_out("s0", 1'b1, 64'h11, 2'd3, 2'd1);
    for (int i = 1; i <= 3; i++) begin
      drive(1'b1, 64'h11 + 64'(i), 2'(i), 1'b1, 1'b0, 1'b0);
      tick();
      chk_out("stream", 1'b1, 64'h11 + 64'(i), 2'(i), 2'd1);
    end
    drive(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("s_drain", 1'b0, 64'h14, 2'd0, 2'd0);

    // skid fill and drain in order
    drive(1'b1, 64'hA, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("k1", 1'b1, 64'hA, 2'd1, 2'd1);
    drive(1'b1, 64'hB, 2'd2, 1'b0, 1'b0, 1'b0);
    chk("k_rdy1", 64'(in_ready), 64'd1);
    tick();
    chk_out("k2", 1'b1, 64'hA, 2'd1, 2'd2);
    drive(1'b1, 64'hF, 2'd3, 1'b0, 1'b0, 1'b0);
    chk("k_full_rdy", 64'(in_ready), 64'd0);
    tick();
    chk_out("k_full", 1'b1, 64'hA, 2'd1, 2'd2);
    drive(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("k_out_b", 1'b1, 64'hB, 2'd2, 2'd1);
    tick();
    chk_out("k_empty", 1'b0, 64'hB, 2'd0, 2'd0);

    // stall freezes a full stage
    fill_ab("st");
    drive(1'b1, 64'hD, 2'd3, 1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("st_rdy", 64'(in_ready), 64'd0);
      tick();
      chk_out("st_hold", 1'b1, 64'hA, 2'd1, 2'd2);
    end
    drive(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("st_b", 1'b1, 64'hB, 2'd2, 2'd1);
    tick();
    chk_out("st_empty", 1'b0, 64'hB, 2'd0, 2'd0);

    // flush beats stall and discards a same-cycle accept
    fill_ab("fl");
    drive(1'b1, 64'hC, 2'd3, 1'b0, 1'b1, 1'b1);
    tick();
    chk("fl_valid", 64'(out_valid), 64'd0);
    chk("fl_ctrl", 64'(out_ctrl), 64'd0);
    chk("fl_occ", 64'(occ), 64'd0);
    drive(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("fl_no_c", 64'(out_valid), 64'd0);

    // payload only sampled on accept
    drive(1'b1, 64'h55, 2'd1, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, 64'h99, 2'd2, 1'b0, 1'b0, 1'b0);
    tick();
    chk_out("samp_hold", 1'b1, 64'h55, 2'd1, 2'd1);
    drive(1'b0, 64'h99, 2'd2, 1'b1, 1'b0, 1'b0);
    tick();
    chk_out("samp_empty", 1'b0, 64'h55, 2'd0, 2'd0);

    // start low mid-operation discards held entries
    fill_ab("rs");
    start = 1'b0;
    drive(1'b1, 64'hE, 2'd1, 1'b1, 1'b0, 1'b0);
    chk("rs_rdy", 64'(in_ready), 64'd0);
    tick();
    chk_out("rs", 1'b0, 64'h0, 2'd0, 2'd0);
    start = 1'b1;
    drive(1'b0, 64'h0, 2'd0, 1'b1, 1'b0, 1'b0);
    tick();
    chk("rs_after", 64'(out_valid), 64'd0);

    // SKID=0 random traffic against a queue model
    for (int n = 0; n < 3000; n++) begin
      in_valid0  = ($urandom_range(0, 3) != 0);
      in_data0   = DW0'($urandom_range(0, 65535));
      in_ctrl0   = CW0'($urandom_range(0, 3));
      out_ready0 = ($urandom_range(0, 2) != 0);
      stall0     = ($urandom_range(0, 7) == 0);
      #1;
      exp_rdy = ~stall0 & ((exp_q.size() == 0) | out_ready0);
      chk("r_rdy", 64'(in_ready0), 64'(exp_rdy));
      chk("r_valid", 64'(out_valid0), 64'(exp_q.size() != 0));
      chk("r_occ", 64'(occ0), 64'(exp_q.size()));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("r_head", 64'({out_data0, out_ctrl0}), 64'(head));
      end else begin
        chk("r_bub_ctrl", 64'(out_ctrl0), 64'd0);
      end
      acc = in_valid0 & exp_rdy;
      xf  = (exp_q.size() != 0) & out_ready0 & ~stall0;
      if (xf) void'(exp_q.pop_front());
      if (acc) exp_q.push_back({in_data0, in_ctrl0});
      tick();
    end

    // ---------------- report ----------------
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
